modaddsub_serial: RTL and testbench

- Limb-serial modular adder/subtractor for the ECC datapath: result = (a + b) mod p or (a − b) mod p, with a, b, p of NUM_LIMBS×LIMB_W bits.
- Processes one LIMB_W-bit limb per cycle, running the raw and the correction carry chains in parallel, then selects the reduced value.
- Sits between the operand register file and the field multiplier/point-arithmetic sequencer.
- Uses a valid/ready handshake on both input and output.

---
 rtl/modaddsub_pkg.sv | 25 ++
 rtl/limb_addsub_cell.sv | 60 ++++++
 rtl/modaddsub_serial.sv | 140 ++++++++++++++
 tb/tb_modaddsub_serial.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/modaddsub_pkg.sv
// ---------------------------------------------------------------------------
// modaddsub_pkg
// Shared definitions for the limb-serial modular adder/subtractor:
//   - op encoding (OP_ADD / OP_SUB)
//   - FSM state type
//   - idx_width(): limb-index register width, clog2(n) but never below 1
// ---------------------------------------------------------------------------
package modaddsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // A single-limb build still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/limb_addsub_cell.sv
// ---------------------------------------------------------------------------
// limb_addsub_cell
// Combinational per-limb slice of the modular add/sub. Produces the raw
// limb (a +/- b) and the corrected limb (raw -/+ p) in the same cycle; the
// correction chain consumes the raw limb just computed, so both chains
// advance together and no second pass over the limbs is needed.
//
// Ports:
//   a_i, b_i, p_i  in   LIMB_W  current limb of a, b and the modulus
//   op             in   1       OP_ADD / OP_SUB
//   c_raw, c_cor   in   1       carry/borrow into the raw / correction chain
//   raw_i, cor_i   out  LIMB_W  raw and corrected limb
//   c_raw_next     out  1       carry/borrow out of the raw chain
//   c_cor_next     out  1       carry/borrow out of the correction chain
// ---------------------------------------------------------------------------
module limb_addsub_cell
  import modaddsub_pkg::*;
#(
  parameter int LIMB_W = 64
) (
  input  logic [LIMB_W-1:0] a_i,
  input  logic [LIMB_W-1:0] b_i,
  input  logic [LIMB_W-1:0] p_i,
  input  logic              op,
  input  logic              c_raw,
  input  logic              c_cor,
  output logic [LIMB_W-1:0] raw_i,
  output logic [LIMB_W-1:0] cor_i,
  output logic              c_raw_next,
  output logic              c_cor_next
);

  // Every operation is exactly LIMB_W+1 bits wide. For subtraction the top
  // bit of the (LIMB_W+1)-bit two's-complement difference is the borrow.
  logic [LIMB_W:0] raw_ext;
  logic [LIMB_W:0] cor_ext;
  logic [LIMB_W:0] c_raw_ext;
  logic [LIMB_W:0] c_cor_ext;

  assign c_raw_ext = {{LIMB_W{1'b0}}, c_raw};
  assign c_cor_ext = {{LIMB_W{1'b0}}, c_cor};

  always_comb begin
    raw_ext = '0;
    cor_ext = '0;
    if (op == OP_ADD) begin
      raw_ext = {1'b0, a_i} + {1'b0, b_i} + c_raw_ext;
      cor_ext = {1'b0, raw_ext[LIMB_W-1:0]} - {1'b0, p_i} - c_cor_ext;
    end else begin
      raw_ext = {1'b0, a_i} - {1'b0, b_i} - c_raw_ext;
      cor_ext = {1'b0, raw_ext[LIMB_W-1:0]} + {1'b0, p_i} + c_cor_ext;
    end
  end

  assign raw_i      = raw_ext[LIMB_W-1:0];
  assign cor_i      = cor_ext[LIMB_W-1:0];
  assign c_raw_next = raw_ext[LIMB_W];
  assign c_cor_next = cor_ext[LIMB_W];

endmodule

// File: rtl/modaddsub_serial.sv
// ---------------------------------------------------------------------------
// modaddsub_serial
// Limb-serial modular adder/subtractor: result = (a + b) mod p or
// (a - b) mod p, one LIMB_W-bit limb per cycle. R holds a +/- b and T holds
// the p-corrected value; the final carries of both chains pick one in SEL.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands and op valid
//   in_ready   out  1  high only in IDLE
//   op         in   1  0 = add, 1 = subtract
//   a, b, p    in   W  operands (a, b < p) and odd modulus p > 2^(W-1)
//   out_valid  out  1  result valid (held in DONE)
//   out_ready  in   1  consumer accepts result
//   result     out  W  reduced result
//
// Timing: accept edge, NUM_LIMBS RUN edges, one SEL edge -> out_valid.
// ---------------------------------------------------------------------------
module modaddsub_serial
  import modaddsub_pkg::*;
#(
  parameter int LIMB_W    = 64,
  parameter int NUM_LIMBS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        op,
  input  logic [LIMB_W*NUM_LIMBS-1:0] a,
  input  logic [LIMB_W*NUM_LIMBS-1:0] b,
  input  logic [LIMB_W*NUM_LIMBS-1:0] p,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LIMB_W*NUM_LIMBS-1:0] result
);

  localparam int W    = LIMB_W * NUM_LIMBS;
  localparam int IDXW = idx_width(NUM_LIMBS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_LIMBS - 1);

  state_t          state_reg;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    p_reg;
  logic [W-1:0]    r_reg;
  logic [W-1:0]    t_reg;
  logic [W-1:0]    result_reg;
  logic            op_reg;
  logic            c_raw_reg;
  logic            c_cor_reg;
  logic [IDXW-1:0] idx_reg;

  logic              accept;
  logic              take_t;
  logic [LIMB_W-1:0] raw_limb;
  logic [LIMB_W-1:0] cor_limb;
  logic              c_raw_next;
  logic              c_cor_next;

  assign accept = in_valid && (state_reg == IDLE);

  limb_addsub_cell #(
    .LIMB_W(LIMB_W)
  ) u_cell (
    .a_i       (a_reg[idx_reg*LIMB_W +: LIMB_W]),
    .b_i       (b_reg[idx_reg*LIMB_W +: LIMB_W]),
    .p_i       (p_reg[idx_reg*LIMB_W +: LIMB_W]),
    .op        (op_reg),
    .c_raw     (c_raw_reg),
    .c_cor     (c_cor_reg),
    .raw_i     (raw_limb),
    .cor_i     (cor_limb),
    .c_raw_next(c_raw_next),
    .c_cor_next(c_cor_next)
  );

  // add: T is right when a+b overflowed W bits or a+b >= p (no final borrow
  //      from subtracting p).
  // sub: T is right when a-b borrowed, i.e. a < b.
  assign take_t = (op_reg == OP_ADD) ? (c_raw_reg | ~c_cor_reg) : c_raw_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      p_reg      <= '0;
      r_reg      <= '0;
      t_reg      <= '0;
      result_reg <= '0;
      op_reg     <= 1'b0;
      c_raw_reg  <= 1'b0;
      c_cor_reg  <= 1'b0;
      idx_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            p_reg     <= p;
            op_reg    <= op;
            c_raw_reg <= 1'b0;
            c_cor_reg <= 1'b0;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          r_reg[idx_reg*LIMB_W +: LIMB_W] <= raw_limb;
          t_reg[idx_reg*LIMB_W +: LIMB_W] <= cor_limb;
          c_raw_reg <= c_raw_next;
          c_cor_reg <= c_cor_next;
          idx_reg   <= idx_reg + IDXW'(1);
          if (idx_reg == LAST_IDX) begin
            state_reg <= SEL;
          end
        end
        SEL: begin
          result_reg <= take_t ? t_reg : r_reg;
          state_reg  <= DONE;
        end
        DONE: begin
          // result_reg is left untouched here so it stays stable while held.
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;

endmodule

// File: tb/tb_modaddsub_serial.sv
module tb_modaddsub_serial;

  localparam int W = 256;
  localparam logic [W-1:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam int NRAND = 2000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] p;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;

  int errors = 0;
  int checks = 0;

  modaddsub_serial dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .p        (p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on wide integers.
  function automatic logic [W-1:0] ref_model(input logic o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic [W+1:0] s;
    if (o == 1'b0) begin
      s = {2'b00, x} + {2'b00, y};
      if (s >= {2'b00, P}) s = s - {2'b00, P};
      return s[W-1:0];
    end else begin
      if (x >= y) return x - y;
      return x - y + P;
    end
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] v;
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return '0;
    if (k == 1) return P - 1;
    if (k == 2) return 256'd1;
    v = '0;
    for (int i = 0; i < 8; i++) v = {v[W-33:0], 32'($urandom)};
    if (v >= P) v = v - P;
    return v;
  endfunction

  // Issue one op with out_ready high; checks latency, in_ready and result.
  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] expv, input string tag);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_idle_timeout"}, W'(n < 50), W'(1));
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      chk({tag, "_in_ready_busy"}, W'(in_ready), W'(0));
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, W'(n), W'(5));
    chk({tag, "_in_ready_done"}, W'(in_ready), W'(0));
    chk(tag, result, expv);
    $display("op=%0d a=%h b=%h result=%h", o, x, y, result);
    @(posedge clk); #1;
    chk({tag, "_out_valid_drop"}, W'(out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] q[$];
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] expv;
    logic         o;
    int           n;
    int           acc;
    int           res;
    int           cyc;

    rst_n = 1'b0; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; p = P; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", result, '0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases
    run_op(1'b0, 256'd1, 256'd2, 256'd3, "add_1_2");
    run_op(1'b0, P - 1, 256'd2, 256'd1, "add_pm1_2");
    run_op(1'b0, P - 1, 256'd1, 256'd0, "add_pm1_1");
    run_op(1'b0, P - 1, P - 1, P - 2, "add_pm1_pm1");
    run_op(1'b1, 256'd0, 256'd1, P - 1, "sub_0_1");
    run_op(1'b1, 256'd5, 256'd5, 256'd0, "sub_5_5");
    run_op(1'b1, 256'h1_0000_0000_0000_0000, 256'd1, 256'hFFFF_FFFF_FFFF_FFFF, "sub_limb_borrow");

    // Backpressure: result held while new operands sit on the input
    out_ready = 1'b0;
    in_valid = 1'b1; op = 1'b0; a = P - 1; b = 256'd2;
    @(posedge clk); #1;
    a = 256'd3; b = 256'd4;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_wait_timeout", W'(n < 50), W'(1));
    for (int i = 0; i < 10; i++) begin
      chk("bp_result_stable", result, 256'd1);
      chk("bp_out_valid_held", W'(out_valid), W'(1));
      chk("bp_no_accept", W'(in_ready), W'(0));
      @(posedge clk); #1;
    end
    $display("op=0 backpressure held result=%h", result);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", W'(out_valid), W'(0));
    chk("bp_release_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    chk("bp_next_accepted", W'(in_ready), W'(0));
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_next_result", result, 256'd7);
    $display("op=0 a=3 b=4 result=%h", result);
    @(posedge clk); #1;

    // Asynchronous reset during limb 2
    in_valid = 1'b1; op = 1'b0; a = P - 1; b = 256'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_result", result, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_out_valid", W'(out_valid), W'(0));
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("postrst_no_out_valid", W'(out_valid), W'(0));
    end
    run_op(1'b0, 256'd7, 256'd8, 256'd15, "add_7_8");

    // Random mixed traffic with random out_ready
    acc = 0; res = 0; cyc = 0;
    while (res < NRAND && cyc < 60000) begin
      if (in_ready && acc < NRAND) begin
        o = 1'($urandom_range(0, 1));
        x = rand_operand();
        y = rand_operand();
        in_valid = 1'b1; op = o; a = x; b = y;
        q.push_back(ref_model(o, x, y));
        acc++;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (q.size() > 0) expv = q.pop_front();
        else expv = 'x;
        chk("rand_result", result, expv);
        $display("rand #%0d result=%h expected=%h", res, result, expv);
        res++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rand_timeout", W'(cyc < 60000), W'(1));
    chk("rand_accepts_eq_results", W'(acc), W'(res));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
